fifo_protocol_checker: RTL and testbench
========================================

// Module: fifo_protocol_checker
// PURPOSE
// - Synthesisable, parametrised protocol and data checker for the fifo_if
//   bus. It sits beside any FIFO DUT in simulation and formal benches.
// - Keeps a shadow reference model of the FIFO and checks overflow and
//   underflow, the full/empty/almost flags, and read-data ordering and
//   integrity.
// - Reports sticky error bits, per-cycle error pulses, a first-error code
//   and a saturating error count.
// PARAMETERS
// DEPTH      8   FIFO entries, >=2. Need not be a power of two.
// DWIDTH     16  data width in bits
// AF_THRESH  6   almost_full is expected when count >= AF_THRESH (1..DEPTH)
// AE_THRESH  2   almost_empty is expected when count <= AE_THRESH (0..DEPTH-1)
// RD_LAT     0   DUT read latency. 0: rd_data is valid in the rd_en cycle.
//                1: rd_data is valid one cycle after rd_en.
// ERRCNT_W   8   width of the error counter
// PORTS
// clk           in   1            clock
// rstn          in   1            synchronous reset, active-low
// wr_en         in   1            DUT write strobe (observed)
// wr_data       in   DWIDTH       DUT write data (observed)
// rd_en         in   1            DUT read strobe (observed)
// rd_data       in   DWIDTH       DUT read data (observed)
// full          in   1            DUT full flag (observed)
// empty         in   1            DUT empty flag (observed)
// almost_full   in   1            DUT almost-full flag (observed)
// almost_empty  in   1            DUT almost-empty flag (observed)
// err_pulse     out  6            errors detected this cycle; bits per ERR_* in the package
// err_sticky    out  6            OR of all err_pulse since the last reset
// first_err     out  3            err_code_e of the earliest error, ERR_NONE if none
// err_cnt       out  ERRCNT_W     cycles with any error, saturating
// model_count   out  clog2(DEPTH+1)  shadow-model occupancy
// BEHAVIOUR
// - Reset: all outputs, pointers, count and the pending-compare stage are 0
//   when rstn=0 at a clk edge. first_err=ERR_NONE. No checks fire in the
//   reset cycle. Checks are active from the first edge with rstn=1.
// - Push/pop acceptance is decided from model_count before the edge:
//   - push when wr_en && count<DEPTH
//   - pop  when rd_en && count>0
//   - count' = count + push - pop
//   - wr_ptr and rd_ptr wrap from DEPTH-1 to 0
// - OVF: wr_en while count==DEPTH. This is a violation even with a
//   simultaneous pop. The write is dropped; the pop still occurs.
// - UNF: rd_en while count==0. No pop and no data compare. A simultaneous
//   write is still pushed.
// - FULL_FLAG: full != (count==DEPTH), every active cycle.
// - EMPTY_FLAG: empty != (count==0), every active cycle.
// - THRESH_FLAG: almost_full != (count>=AF_THRESH), or
//   almost_empty != (count<=AE_THRESH).
// - DATA compare:
//   - RD_LAT=0: in the pop cycle, compare rd_data with mem[rd_ptr].
//   - RD_LAT=1: the pop registers the expected word plus a valid bit; the
//     next cycle compares rd_data against it. The valid bit clears unless a
//     new pop occurs.
//   - Push and pop in the same cycle with count==0 are never both accepted
//     (UNF), so there is no write-through case.
// - Outputs and registers:
//   - err_pulse is combinational from the current inputs and registered
//     state. err_sticky, first_err and err_cnt are registered.
//   - err_sticky' = err_sticky | err_pulse.
//   - first_err is loaded only while it is ERR_NONE. If several bits fire
//     together, the lowest bit index wins.
//   - err_cnt increments when |err_pulse and holds at all-ones.
// - Reset mid-operation: a pending RD_LAT=1 compare is discarded. Model
//   contents are not cleared; they are don't-care because count=0.
// - Arithmetic: pointers are clog2(DEPTH) bits; count is clog2(DEPTH+1)
//   bits. No truncation is allowed in count +/- 1.
// STRUCTURE
// - fifo_chk_pkg:
//   - err_code_e (3b): ERR_NONE, ERR_OVF, ERR_UNF, ERR_FULL, ERR_EMPTY,
//     ERR_THRESH, ERR_DATA
//   - localparams ERR_OVF_B=0, ERR_UNF_B=1, ERR_FULL_B=2, ERR_EMPTY_B=3,
//     ERR_THR_B=4, ERR_DATA_B=5, N_ERR=6
// - Sub-module fifo_ref_model: shadow memory, pointers, count, push/pop
//   acceptance, and the expected-data output. The top-level holds the flag
//   checks, the latency stage and the error bookkeeping.
// TESTING
// - DEPTH=8, write 8 words 0x0001..0x0008, then read 8:
//   -> no err_pulse; model_count 8 -> 0; full high for exactly the cycles
//   at count 8.
// - Fill to 8, then wr_en=1 with rd_en=0:
//   -> err_pulse[0]=1; first_err=ERR_OVF; model_count stays 8; err_cnt=1.
// - Empty FIFO, rd_en=1 with wr_en=1 and data 0xABCD:
//   -> err_pulse[1]=1; model_count=1; the next read of 0xABCD passes.
// - Count=3, DUT drives empty=1:
//   -> err_pulse[3]=1. With AF_THRESH=6 at count=6 and almost_full=0
//   -> err_pulse[4]=1.
// - RD_LAT=1: push 0x1111,0x2222; pop twice; DUT returns 0x1111 then 0x2223
//   -> err_pulse[5]=1 in the second data cycle only.
// - Pop with RD_LAT=1, rstn=0 on the next edge:
//   -> no DATA error after reset; all outputs 0; first_err=ERR_NONE.

Source files
------------

// File: rtl/fifo_chk_pkg.sv
// Shared types and constants for the fifo_if protocol checker.
// err_code_e names the earliest error; the *_B localparams index err_pulse/err_sticky.
package fifo_chk_pkg;

  localparam int unsigned ERR_OVF_B   = 0;
  localparam int unsigned ERR_UNF_B   = 1;
  localparam int unsigned ERR_FULL_B  = 2;
  localparam int unsigned ERR_EMPTY_B = 3;
  localparam int unsigned ERR_THR_B   = 4;
  localparam int unsigned ERR_DATA_B  = 5;
  localparam int unsigned N_ERR       = 6;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_OVF    = 3'd1,
    ERR_UNF    = 3'd2,
    ERR_FULL   = 3'd3,
    ERR_EMPTY  = 3'd4,
    ERR_THRESH = 3'd5,
    ERR_DATA   = 3'd6
  } err_code_e;

  // Code of the lowest set error bit; bit b maps to code b+1.
  function automatic err_code_e first_code(input logic [N_ERR-1:0] p);
    err_code_e c;
    c = ERR_NONE;
    for (int i = N_ERR - 1; i >= 0; i--) begin
      if (p[i]) c = err_code_e'(3'(i + 1));
    end
    return c;
  endfunction

endpackage

// File: rtl/fifo_ref_model.sv
// Shadow FIFO: memory, wrapping pointers, occupancy and push/pop acceptance.
// Ports: clk/rstn (sync, active-low); observed wr_en/wr_data/rd_en;
//        count (registered occupancy); push_c/pop_c accepted this cycle;
//        full_c/empty_c from count; rd_word_c = word at the read pointer.
module fifo_ref_model
  import fifo_chk_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DWIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_en,
  input  logic [DWIDTH-1:0]            wr_data,
  input  logic                         rd_en,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         push_c,
  output logic                         pop_c,
  output logic                         full_c,
  output logic                         empty_c,
  output logic [DWIDTH-1:0]            rd_word_c
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Acceptance is decided from the pre-edge occupancy.
  assign full_c    = (count == CW'(DEPTH));
  assign empty_c   = (count == '0);
  assign push_c    = rstn && wr_en && !full_c;
  assign pop_c     = rstn && rd_en && !empty_c;
  assign rd_word_c = mem[rd_ptr];

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_c)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Contents are left alone on reset; they are unreachable while count is 0.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fifo_protocol_checker.sv
// Protocol/data checker for a FIFO on the fifo_if bus.
// Ports: clk/rstn (sync, active-low); observed wr_en, wr_data, rd_en, rd_data,
//        full, empty, almost_full, almost_empty;
//        err_pulse (this cycle), err_sticky, first_err, err_cnt (saturating),
//        model_count (shadow occupancy).
module fifo_protocol_checker
  import fifo_chk_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned RD_LAT    = 0,
  parameter int unsigned ERRCNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_en,
  input  logic [DWIDTH-1:0]            wr_data,
  input  logic                         rd_en,
  input  logic [DWIDTH-1:0]            rd_data,
  input  logic                         full,
  input  logic                         empty,
  input  logic                         almost_full,
  input  logic                         almost_empty,
  output logic [N_ERR-1:0]             err_pulse,
  output logic [N_ERR-1:0]             err_sticky,
  output err_code_e                    first_err,
  output logic [ERRCNT_W-1:0]          err_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   model_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic              m_push;
  logic              m_pop;
  logic              m_full;
  logic              m_empty;
  logic [DWIDTH-1:0] m_word;
  logic              exp_vld;
  logic [DWIDTH-1:0] exp_word;

  fifo_ref_model #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH)
  ) u_model (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .count     (model_count),
    .push_c    (m_push),
    .pop_c     (m_pop),
    .full_c    (m_full),
    .empty_c   (m_empty),
    .rd_word_c (m_word)
  );

  // Per-cycle checks; silent during the reset cycle.
  always_comb begin
    err_pulse = '0;
    if (rstn) begin
      err_pulse[ERR_OVF_B]   = wr_en && m_full;
      err_pulse[ERR_UNF_B]   = rd_en && m_empty;
      err_pulse[ERR_FULL_B]  = (full != m_full);
      err_pulse[ERR_EMPTY_B] = (empty != m_empty);
      err_pulse[ERR_THR_B]   = (almost_full  != (model_count >= CW'(AF_THRESH))) ||
                               (almost_empty != (model_count <= CW'(AE_THRESH)));
      if (RD_LAT == 0) err_pulse[ERR_DATA_B] = m_pop && (rd_data != m_word);
      else             err_pulse[ERR_DATA_B] = exp_vld && (rd_data != exp_word);
    end
  end

  // Latency stage: holds the word a pop expects to see on the next cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      exp_vld  <= 1'b0;
      exp_word <= '0;
    end else begin
      exp_vld <= m_pop;
      if (m_pop) exp_word <= m_word;
    end
  end

  // Error bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_sticky <= '0;
      first_err  <= ERR_NONE;
      err_cnt    <= '0;
    end else begin
      err_sticky <= err_sticky | err_pulse;
      if (first_err == ERR_NONE && |err_pulse) first_err <= first_code(err_pulse);
      if (|err_pulse && err_cnt != '1) err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_protocol_checker.sv
// Bench for fifo_protocol_checker: one RD_LAT=0 instance and one RD_LAT=1
// instance (3-bit error counter) watching the same bus, checked against a
// queue-based model of the FIFO rules.
module tb_fifo_protocol_checker;
  import fifo_chk_pkg::*;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, wr_en, rd_en, full, empty, almost_full, almost_empty;
  logic [15:0] wr_data, rd_data0, rd_data1;
  logic [5:0]  pulse0, pulse1, sticky0, sticky1;
  err_code_e   first0, first1;
  logic [7:0]  cnt0;
  logic [2:0]  cnt1;
  logic [3:0]  mc0, mc1;

  fifo_protocol_checker #(.DEPTH(8), .DWIDTH(16), .AF_THRESH(6), .AE_THRESH(2),
                          .RD_LAT(0), .ERRCNT_W(8)) dut0 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .err_pulse(pulse0), .err_sticky(sticky0),
    .first_err(first0), .err_cnt(cnt0), .model_count(mc0));

  fifo_protocol_checker #(.DEPTH(8), .DWIDTH(16), .AF_THRESH(6), .AE_THRESH(2),
                          .RD_LAT(1), .ERRCNT_W(3)) dut1 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .err_pulse(pulse1), .err_sticky(sticky1),
    .first_err(first1), .err_cnt(cnt1), .model_count(mc1));

  // Reference state
  logic [15:0] q[$];
  bit          pend_vld;
  logic [15:0] pend_word;
  logic [5:0]  m_sticky[2];
  logic [2:0]  m_first[2];
  int          m_cnt[2];
  int          cmax[2] = '{255, 7};
  logic [5:0]  exp_p[2], obs_p[2];
  int          exp_mc;
  int          obs_mc[2];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Drive a bus cycle with flags and read data consistent with the model.
  task automatic drive(input bit w, input logic [15:0] wd, input bit r);
    int n;
    n = q.size();
    wr_en = w; wr_data = wd; rd_en = r;
    full = (n == DEPTH); empty = (n == 0);
    almost_full = (n >= AF); almost_empty = (n <= AE);
    rd_data0 = (n > 0) ? q[0] : 16'($urandom);
    rd_data1 = pend_vld ? pend_word : 16'($urandom);
  endtask

  // Called at negedge with inputs set: samples pulses, advances one edge.
  task automatic tick();
    int n;
    bit pop, push;
    n = q.size();
    #1;
    exp_p[0] = '0; exp_p[1] = '0;
    pop  = rstn && rd_en && (n > 0);
    push = rstn && wr_en && (n < DEPTH);
    if (rstn) begin
      for (int d = 0; d < 2; d++) begin
        exp_p[d][0] = wr_en && (n == DEPTH);
        exp_p[d][1] = rd_en && (n == 0);
        exp_p[d][2] = (full != (n == DEPTH));
        exp_p[d][3] = (empty != (n == 0));
        exp_p[d][4] = (almost_full != (n >= AF)) || (almost_empty != (n <= AE));
      end
      exp_p[0][5] = pop && (rd_data0 != q[0]);
      exp_p[1][5] = pend_vld && (rd_data1 != pend_word);
    end
    obs_p[0] = pulse0; obs_p[1] = pulse1;
    obs_mc[0] = int'(mc0); obs_mc[1] = int'(mc1);
    exp_mc = n;
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      pend_vld = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_sticky[d] = '0; m_first[d] = '0; m_cnt[d] = 0;
      end
    end else begin
      pend_vld = pop;
      if (pop) begin
        pend_word = q[0];
        void'(q.pop_front());
      end
      if (push) q.push_back(wr_data);
      for (int d = 0; d < 2; d++) begin
        m_sticky[d] = m_sticky[d] | exp_p[d];
        if (m_first[d] == 3'd0)
          for (int b = 5; b >= 0; b--) if (exp_p[d][b]) m_first[d] = 3'(b + 1);
        if (exp_p[d] != '0 && m_cnt[d] < cmax[d]) m_cnt[d]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(1'b1, 16'hDEAD, 1'b1);
    full = 1'b1; empty = 1'b0;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_p[d] !== 6'b0) begin n_fail++; $display("FAIL reset_pulse%0d: got %b expected 000000", d, obs_p[d]); end
    end
    n_checks++;
    if (sticky0 !== 6'b0 || sticky1 !== 6'b0) begin n_fail++; $display("FAIL reset_sticky: got %b/%b expected 0", sticky0, sticky1); end
    n_checks++;
    if (first0 !== ERR_NONE || first1 !== ERR_NONE) begin n_fail++; $display("FAIL reset_first: got %0d/%0d expected 0", first0, first1); end
    n_checks++;
    if (cnt0 !== 8'd0 || cnt1 !== 3'd0 || mc0 !== 4'd0 || mc1 !== 4'd0) begin
      n_fail++; $display("FAIL reset_counts: cnt %0d/%0d mc %0d/%0d expected 0", cnt0, cnt1, mc0, mc1);
    end
    rstn = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b0); tick();
      n_checks++;
      if (obs_p[0] !== 6'b0 || obs_p[1] !== 6'b0 || obs_mc[0] != i - 1) begin
        n_fail++; $display("FAIL fill_%0d: pulse %b/%b count %0d expected 0/0 count %0d", i, obs_p[0], obs_p[1], obs_mc[0], i - 1);
      end
    end
    n_checks++;
    if (mc0 !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d expected 8", mc0); end
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 16'h0, i < 8); tick();
      n_checks++;
      if (obs_p[0] !== 6'b0 || obs_p[1] !== 6'b0 || obs_mc[1] != (i < 8 ? 8 - i : 0)) begin
        n_fail++; $display("FAIL drain_%0d: pulse %b/%b count %0d", i, obs_p[0], obs_p[1], obs_mc[1]);
      end
    end
    n_checks++;
    if (mc0 !== 4'd0 || sticky0 !== 6'b0 || sticky1 !== 6'b0) begin
      n_fail++; $display("FAIL drain_end: count %0d sticky %b/%b expected 0", mc0, sticky0, sticky1);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin drive(1'b1, 16'h0100 + 16'(i), 1'b0); tick(); end
    drive(1'b1, 16'h5555, 1'b0); tick();
    n_checks++;
    if (obs_p[0] !== 6'b000001 || obs_p[1] !== 6'b000001) begin n_fail++; $display("FAIL ovf_pulse: got %b/%b expected 000001", obs_p[0], obs_p[1]); end
    n_checks++;
    if (first0 !== ERR_OVF || first1 !== ERR_OVF) begin n_fail++; $display("FAIL ovf_first: got %0d/%0d expected 1", first0, first1); end
    n_checks++;
    if (mc0 !== 4'd8 || cnt0 !== 8'd1 || cnt1 !== 3'd1) begin n_fail++; $display("FAIL ovf_counts: mc %0d cnt %0d/%0d expected 8,1,1", mc0, cnt0, cnt1); end
    drive(1'b1, 16'h6666, 1'b1); tick();
    n_checks++;
    if (obs_p[0] !== 6'b000001 || mc0 !== 4'd7) begin n_fail++; $display("FAIL ovf_with_pop: pulse %b count %0d expected 000001,7", obs_p[0], mc0); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 16'h0, i < 7); tick();
      n_checks++;
      if (obs_p[0] !== exp_p[0] || obs_p[1] !== exp_p[1]) begin n_fail++; $display("FAIL ovf_drain_%0d: got %b/%b expected %b/%b", i, obs_p[0], obs_p[1], exp_p[0], exp_p[1]); end
    end
  endtask

  task automatic test_underflow();
    drive(1'b1, 16'hABCD, 1'b1); tick();
    n_checks++;
    if (obs_p[0] !== 6'b000010 || obs_p[1] !== 6'b000010) begin n_fail++; $display("FAIL unf_pulse: got %b/%b expected 000010", obs_p[0], obs_p[1]); end
    n_checks++;
    if (mc0 !== 4'd1 || mc1 !== 4'd1) begin n_fail++; $display("FAIL unf_count: got %0d/%0d expected 1", mc0, mc1); end
    drive(1'b0, 16'h0, 1'b1); rd_data0 = 16'hABCD; tick();
    n_checks++;
    if (obs_p[0] !== 6'b0) begin n_fail++; $display("FAIL unf_read0: got %b expected 000000", obs_p[0]); end
    drive(1'b0, 16'h0, 1'b0); rd_data1 = 16'hABCD; tick();
    n_checks++;
    if (obs_p[1] !== 6'b0 || mc0 !== 4'd0) begin n_fail++; $display("FAIL unf_read1: got %b count %0d expected 000000,0", obs_p[1], mc0); end
  endtask

  task automatic test_flags();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 16'($urandom), 1'b0); tick(); end
    drive(1'b0, 16'h0, 1'b0); empty = 1'b1; tick();
    n_checks++;
    if (obs_p[0] !== 6'b001000 || obs_p[1] !== 6'b001000) begin n_fail++; $display("FAIL empty_flag: got %b/%b expected 001000", obs_p[0], obs_p[1]); end
    for (int i = 0; i < 3; i++) begin drive(1'b1, 16'($urandom), 1'b0); tick(); end
    drive(1'b0, 16'h0, 1'b0); almost_full = 1'b0; tick();
    n_checks++;
    if (obs_p[0] !== 6'b010000 || obs_p[1] !== 6'b010000) begin n_fail++; $display("FAIL af_flag: got %b/%b expected 010000", obs_p[0], obs_p[1]); end
    drive(1'b0, 16'h0, 1'b0); full = 1'b1; tick();
    n_checks++;
    if (obs_p[0] !== 6'b000100) begin n_fail++; $display("FAIL full_flag: got %b expected 000100", obs_p[0]); end
    for (int i = 0; i < 7; i++) begin drive(1'b0, 16'h0, i < 6); tick(); end
  endtask

  task automatic test_lat1_data();
    drive(1'b1, 16'h1111, 1'b0); tick();
    drive(1'b1, 16'h2222, 1'b0); tick();
    drive(1'b0, 16'h0, 1'b1); tick();
    drive(1'b0, 16'h0, 1'b1); rd_data1 = 16'h1111; tick();
    n_checks++;
    if (obs_p[1] !== 6'b0 || obs_p[0] !== 6'b0) begin n_fail++; $display("FAIL lat1_first: got %b/%b expected 000000", obs_p[0], obs_p[1]); end
    drive(1'b0, 16'h0, 1'b0); rd_data1 = 16'h2223; tick();
    n_checks++;
    if (obs_p[1] !== 6'b100000) begin n_fail++; $display("FAIL lat1_second: got %b expected 100000", obs_p[1]); end
    drive(1'b0, 16'h0, 1'b0); rd_data1 = 16'h7777; tick();
    n_checks++;
    if (obs_p[1] !== 6'b0) begin n_fail++; $display("FAIL lat1_vld_clear: got %b expected 000000", obs_p[1]); end
  endtask

  task automatic test_reset_pending();
    drive(1'b1, 16'h4242, 1'b0); tick();
    drive(1'b0, 16'h0, 1'b1); tick();
    drive(1'b0, 16'h0, 1'b0); rd_data1 = 16'hBDBD; rstn = 1'b0; tick();
    n_checks++;
    if (obs_p[1] !== 6'b0) begin n_fail++; $display("FAIL rstp_pulse: got %b expected 000000", obs_p[1]); end
    n_checks++;
    if (sticky0 !== 6'b0 || sticky1 !== 6'b0 || first0 !== ERR_NONE || first1 !== ERR_NONE || cnt0 !== 8'd0 || cnt1 !== 3'd0) begin
      n_fail++; $display("FAIL rstp_regs: sticky %b/%b first %0d/%0d cnt %0d/%0d expected 0", sticky0, sticky1, first0, first1, cnt0, cnt1);
    end
    rstn = 1'b1;
    drive(1'b0, 16'h0, 1'b0); rd_data1 = 16'hBEEF; tick();
    n_checks++;
    if (obs_p[1] !== 6'b0 || mc1 !== 4'd0) begin n_fail++; $display("FAIL rstp_after: got %b count %0d expected 000000,0", obs_p[1], mc1); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 50);
      case ($urandom_range(0, 19))
        0: full = ~full;
        1: empty = ~empty;
        2: almost_full = ~almost_full;
        3: almost_empty = ~almost_empty;
        4: rd_data0 = rd_data0 ^ 16'(1 << $urandom_range(0, 15));
        5: rd_data1 = rd_data1 ^ 16'(1 << $urandom_range(0, 15));
        default: ;
      endcase
      tick();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs_p[d] !== exp_p[d] || obs_mc[d] != exp_mc) begin
          n_fail++; $display("FAIL rand_pulse%0d c%0d: got %b cnt %0d expected %b cnt %0d", d, c, obs_p[d], obs_mc[d], exp_p[d], exp_mc);
        end
      end
      n_checks++;
      if (sticky0 !== m_sticky[0] || sticky1 !== m_sticky[1]) begin
        n_fail++; $display("FAIL rand_sticky c%0d: got %b/%b expected %b/%b", c, sticky0, sticky1, m_sticky[0], m_sticky[1]);
      end
      n_checks++;
      if (first0 !== err_code_e'(m_first[0]) || first1 !== err_code_e'(m_first[1])) begin
        n_fail++; $display("FAIL rand_first c%0d: got %0d/%0d expected %0d/%0d", c, first0, first1, m_first[0], m_first[1]);
      end
      n_checks++;
      if (int'(cnt0) != m_cnt[0] || int'(cnt1) != m_cnt[1]) begin
        n_fail++; $display("FAIL rand_errcnt c%0d: got %0d/%0d expected %0d/%0d", c, cnt0, cnt1, m_cnt[0], m_cnt[1]);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    rd_data0 = '0; rd_data1 = '0; full = 1'b0; empty = 1'b1;
    almost_full = 1'b0; almost_empty = 1'b1;
    pend_vld = 1'b0; pend_word = '0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_flags();
    test_lat1_data();
    test_reset_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
